key_debounce: RTL and testbench

//  Front-end conditioning stage between the raw push-button pins (KEY) and the edge/level logic.
//  Per key:
//   - two-flop synchronizer, then counter-based debounce;
//   - outputs a clean level, single-cycle press/release pulses, and an optional auto-repeat pulse train.

---
 rtl/key_debounce_pkg.sv | 20 ++
 rtl/key_debounce_if.sv | 20 ++
 rtl/key_debounce_ch.sv | 125 ++++++++++++
 rtl/key_debounce.sv | 50 +++++
 tb/tb_key_debounce.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/key_debounce_pkg.sv
// Shared types and default timing for the push-button conditioning front end.
// Defaults assume a 50 MHz system clock.
package key_debounce_pkg;

    localparam int DEF_N_KEYS            = 4;
    localparam int DEF_DEBOUNCE_CYC      = 500000;    // 10 ms
    localparam int DEF_REPEAT_DELAY_CYC  = 25000000;  // 500 ms
    localparam int DEF_REPEAT_PERIOD_CYC = 5000000;   // 100 ms

    typedef enum logic [1:0] {
        HOLD_IDLE   = 2'd0,
        HOLD_WAIT   = 2'd1,
        HOLD_REPEAT = 2'd2
    } hold_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_debounce_if.sv
// Bundle of raw key pins and the conditioned per-key level/pulse outputs.
interface key_debounce_if #(
    parameter int N_KEYS = 4
);
    logic [N_KEYS-1:0] key_in;
    logic [N_KEYS-1:0] key_level;
    logic [N_KEYS-1:0] press_pulse;
    logic [N_KEYS-1:0] release_pulse;
    logic [N_KEYS-1:0] repeat_pulse;

    modport master (
        output key_in,
        input  key_level, press_pulse, release_pulse, repeat_pulse
    );

    modport slave (
        input  key_in,
        output key_level, press_pulse, release_pulse, repeat_pulse
    );
endinterface

// File: rtl/key_debounce_ch.sv
// One key channel: two-flop synchronizer, counter debounce, and hold/auto-repeat FSM.
module key_debounce_ch
    import key_debounce_pkg::*;
#(
    parameter int ACTIVE_LOW        = 1,
    parameter int DEBOUNCE_CYC      = DEF_DEBOUNCE_CYC,
    parameter int REPEAT_DELAY_CYC  = DEF_REPEAT_DELAY_CYC,
    parameter int REPEAT_PERIOD_CYC = DEF_REPEAT_PERIOD_CYC,
    parameter bit REPEAT_EN         = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic key_raw,
    output logic key_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse
);

    localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
    localparam int RP_W = $clog2(max_int(REPEAT_DELAY_CYC, REPEAT_PERIOD_CYC) + 1);
    localparam logic PIN_RELEASED = (ACTIVE_LOW != 0);
    localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [RP_W-1:0] DELAY_LAST = RP_W'(REPEAT_DELAY_CYC - 1);
    localparam logic [RP_W-1:0] PERIOD_LAST = RP_W'(REPEAT_PERIOD_CYC - 1);

    logic              sync1_reg, sync2_reg;
    logic              stable_reg, stable_next;
    logic [DB_W-1:0]   db_cnt_reg, db_cnt_next;
    hold_state_t       state_reg, state_next;
    logic [RP_W-1:0]   rp_cnt_reg, rp_cnt_next;
    logic              press_reg, press_next;
    logic              release_reg, release_next;
    logic              repeat_reg, repeat_next;
    logic              s;

    assign s = (ACTIVE_LOW != 0) ? ~sync2_reg : sync2_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_reg   <= PIN_RELEASED;
            sync2_reg   <= PIN_RELEASED;
            stable_reg  <= 1'b0;
            db_cnt_reg  <= '0;
            state_reg   <= HOLD_IDLE;
            rp_cnt_reg  <= '0;
            press_reg   <= 1'b0;
            release_reg <= 1'b0;
            repeat_reg  <= 1'b0;
        end else begin
            sync1_reg   <= key_raw;
            sync2_reg   <= sync1_reg;
            stable_reg  <= stable_next;
            db_cnt_reg  <= db_cnt_next;
            state_reg   <= state_next;
            rp_cnt_reg  <= rp_cnt_next;
            press_reg   <= press_next;
            release_reg <= release_next;
            repeat_reg  <= repeat_next;
        end
    end

    always_comb begin
        stable_next  = stable_reg;
        db_cnt_next  = '0;
        state_next   = state_reg;
        rp_cnt_next  = rp_cnt_reg;
        press_next   = 1'b0;
        release_next = 1'b0;
        repeat_next  = 1'b0;

        // Any return to the stable value restarts the count from zero.
        if (s != stable_reg) begin
            if (db_cnt_reg == DB_LAST) begin
                stable_next  = s;
                press_next   = s;
                release_next = ~s;
            end else begin
                db_cnt_next = db_cnt_reg + 1'b1;
            end
        end

        case (state_reg)
            HOLD_IDLE: begin
                rp_cnt_next = '0;
                if (press_next && REPEAT_EN)
                    state_next = HOLD_WAIT;
            end
            HOLD_WAIT: begin
                if (rp_cnt_reg == DELAY_LAST) begin
                    repeat_next = 1'b1;
                    rp_cnt_next = '0;
                    state_next  = HOLD_REPEAT;
                end else begin
                    rp_cnt_next = rp_cnt_reg + 1'b1;
                end
            end
            HOLD_REPEAT: begin
                if (rp_cnt_reg == PERIOD_LAST) begin
                    repeat_next = 1'b1;
                    rp_cnt_next = '0;
                end else begin
                    rp_cnt_next = rp_cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next  = HOLD_IDLE;
                rp_cnt_next = '0;
            end
        endcase

        // An accepted release wins over a repeat due on the same edge.
        if (release_next) begin
            state_next  = HOLD_IDLE;
            rp_cnt_next = '0;
            repeat_next = 1'b0;
        end
    end

    assign key_level     = stable_reg;
    assign press_pulse   = press_reg;
    assign release_pulse = release_reg;
    assign repeat_pulse  = REPEAT_EN ? repeat_reg : 1'b0;

endmodule

// File: rtl/key_debounce.sv
// Push-button front end: N_KEYS independent debounce channels behind one interface.
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int              N_KEYS            = DEF_N_KEYS,
    parameter int              ACTIVE_LOW        = 1,
    parameter int              DEBOUNCE_CYC      = DEF_DEBOUNCE_CYC,
    parameter int              REPEAT_DELAY_CYC  = DEF_REPEAT_DELAY_CYC,
    parameter int              REPEAT_PERIOD_CYC = DEF_REPEAT_PERIOD_CYC,
    parameter logic [N_KEYS-1:0] REPEAT_MASK     = 4'b0011
) (
    input  logic         clk,
    input  logic         reset,
    key_debounce_if.slave kb
);

    if (N_KEYS < 1 || DEBOUNCE_CYC < 2 || REPEAT_DELAY_CYC < 1 || REPEAT_PERIOD_CYC < 1) begin : g_param_check
        $error("key_debounce: illegal parameters (N_KEYS>=1, DEBOUNCE_CYC>=2, repeat params>=1)");
    end

    logic [N_KEYS-1:0] level_w;
    logic [N_KEYS-1:0] press_w;
    logic [N_KEYS-1:0] release_w;
    logic [N_KEYS-1:0] repeat_w;

    genvar gi;
    for (gi = 0; gi < N_KEYS; gi++) begin : g_ch
        key_debounce_ch #(
            .ACTIVE_LOW        (ACTIVE_LOW),
            .DEBOUNCE_CYC      (DEBOUNCE_CYC),
            .REPEAT_DELAY_CYC  (REPEAT_DELAY_CYC),
            .REPEAT_PERIOD_CYC (REPEAT_PERIOD_CYC),
            .REPEAT_EN         (REPEAT_MASK[gi])
        ) u_ch (
            .clk           (clk),
            .reset         (reset),
            .key_raw       (kb.key_in[gi]),
            .key_level     (level_w[gi]),
            .press_pulse   (press_w[gi]),
            .release_pulse (release_w[gi]),
            .repeat_pulse  (repeat_w[gi])
        );
    end

    assign kb.key_level     = level_w;
    assign kb.press_pulse   = press_w;
    assign kb.release_pulse = release_w;
    assign kb.repeat_pulse  = repeat_w;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with short timing (debounce 8, repeat delay 20, period 5).
module tb_key_debounce;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   passes = 0;

    key_debounce_if #(.N_KEYS(4)) kb();

    key_debounce #(
        .N_KEYS            (4),
        .ACTIVE_LOW        (1),
        .DEBOUNCE_CYC      (8),
        .REPEAT_DELAY_CYC  (20),
        .REPEAT_PERIOD_CYC (5),
        .REPEAT_MASK       (4'b0011)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .kb    (kb)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 ns after the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        kb.key_in = 4'hF;
        repeat (3) step();
        checks++; if (kb.key_level !== 4'b0000) $display("FAIL reset_level got %b expected %b", kb.key_level, 4'b0000); else passes++;
        checks++; if (kb.press_pulse !== 4'b0000) $display("FAIL reset_press got %b expected %b", kb.press_pulse, 4'b0000); else passes++;
        checks++; if (kb.release_pulse !== 4'b0000) $display("FAIL reset_release got %b expected %b", kb.release_pulse, 4'b0000); else passes++;
        checks++; if (kb.repeat_pulse !== 4'b0000) $display("FAIL reset_repeat got %b expected %b", kb.repeat_pulse, 4'b0000); else passes++;
        reset = 1'b0;
        repeat (12) begin
            step();
            checks++; if (kb.key_level !== 4'b0000 || kb.press_pulse !== 4'b0000) $display("FAIL idle_after_reset level %b press %b expected 0000 0000", kb.key_level, kb.press_pulse); else passes++;
        end
        $display("test_reset: outputs cleared, idle keys quiet");
    endtask

    // Key 0 clean press; press pulse exactly 10 clocks after the pin edge.
    task automatic test_clean_press();
        logic [3:0] exp_press, exp_level;
        kb.key_in[0] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            exp_press = (k == 10) ? 4'b0001 : 4'b0000;
            exp_level = (k >= 10) ? 4'b0001 : 4'b0000;
            checks++; if (kb.press_pulse !== exp_press) $display("FAIL clean_press_pulse cyc %0d got %b expected %b", k, kb.press_pulse, exp_press); else passes++;
            checks++; if (kb.key_level !== exp_level) $display("FAIL clean_press_level cyc %0d got %b expected %b", k, kb.key_level, exp_level); else passes++;
            checks++; if (kb.release_pulse !== 4'b0000 || kb.repeat_pulse !== 4'b0000) $display("FAIL clean_press_other cyc %0d release %b repeat %b expected 0000 0000", k, kb.release_pulse, kb.repeat_pulse); else passes++;
        end
        $display("test_clean_press: key0 press accepted at +10");
    endtask

    // Continues from test_clean_press with key 0 still held.
    task automatic test_auto_repeat();
        logic [3:0] exp_rep, exp_rel, exp_level;
        int nrep = 0;
        for (int j = 1; j <= 60; j++) begin
            step();
            exp_rep = (j >= 20 && (j - 20) % 5 == 0) ? 4'b0001 : 4'b0000;
            if (kb.repeat_pulse[0] === 1'b1) nrep++;
            checks++; if (kb.repeat_pulse !== exp_rep) $display("FAIL repeat_pulse +%0d got %b expected %b", j, kb.repeat_pulse, exp_rep); else passes++;
            checks++; if (kb.press_pulse !== 4'b0000 || kb.key_level !== 4'b0001) $display("FAIL repeat_hold +%0d press %b level %b expected 0000 0001", j, kb.press_pulse, kb.key_level); else passes++;
        end
        checks++; if (nrep != 9) $display("FAIL repeat_count got %0d expected %0d", nrep, 9); else passes++;
        kb.key_in[0] = 1'b1;
        for (int m = 1; m <= 20; m++) begin
            step();
            exp_rep   = (m == 5) ? 4'b0001 : 4'b0000;
            exp_rel   = (m == 10) ? 4'b0001 : 4'b0000;
            exp_level = (m < 10) ? 4'b0001 : 4'b0000;
            checks++; if (kb.repeat_pulse !== exp_rep) $display("FAIL repeat_at_release cyc %0d got %b expected %b", m, kb.repeat_pulse, exp_rep); else passes++;
            checks++; if (kb.release_pulse !== exp_rel) $display("FAIL release_pulse0 cyc %0d got %b expected %b", m, kb.release_pulse, exp_rel); else passes++;
            checks++; if (kb.key_level !== exp_level) $display("FAIL release_level0 cyc %0d got %b expected %b", m, kb.key_level, exp_level); else passes++;
        end
        $display("test_auto_repeat: %0d repeats while held, release at +10", nrep);
    endtask

    // Key 1 bounces every 3 clocks for 30 clocks, final edge at 30 -> press at 40.
    task automatic test_bounce();
        logic [3:0] exp_press, exp_level, exp_rel;
        for (int t = 0; t < 45; t++) begin
            if (t < 30) kb.key_in[1] = ((t / 3) % 2 == 0) ? 1'b0 : 1'b1;
            else        kb.key_in[1] = 1'b0;
            step();
            exp_press = (t + 1 == 40) ? 4'b0010 : 4'b0000;
            exp_level = (t + 1 >= 40) ? 4'b0010 : 4'b0000;
            checks++; if (kb.press_pulse !== exp_press) $display("FAIL bounce_press cyc %0d got %b expected %b", t + 1, kb.press_pulse, exp_press); else passes++;
            checks++; if (kb.key_level !== exp_level) $display("FAIL bounce_level cyc %0d got %b expected %b", t + 1, kb.key_level, exp_level); else passes++;
        end
        kb.key_in[1] = 1'b1;
        for (int m = 1; m <= 12; m++) begin
            step();
            exp_rel = (m == 10) ? 4'b0010 : 4'b0000;
            checks++; if (kb.release_pulse !== exp_rel || kb.repeat_pulse !== 4'b0000) $display("FAIL bounce_release cyc %0d release %b repeat %b expected %b 0000", m, kb.release_pulse, kb.repeat_pulse, exp_rel); else passes++;
        end
        $display("test_bounce: key1 single press after bounce");
    endtask

    // Key 3 has auto-repeat masked off.
    task automatic test_no_repeat_mask();
        logic [3:0] exp_press, exp_rel;
        kb.key_in[3] = 1'b0;
        for (int k = 1; k <= 70; k++) begin
            step();
            exp_press = (k == 10) ? 4'b1000 : 4'b0000;
            checks++; if (kb.press_pulse !== exp_press || kb.repeat_pulse !== 4'b0000) $display("FAIL mask_hold cyc %0d press %b repeat %b expected %b 0000", k, kb.press_pulse, kb.repeat_pulse, exp_press); else passes++;
        end
        kb.key_in[3] = 1'b1;
        for (int m = 1; m <= 12; m++) begin
            step();
            exp_rel = (m == 10) ? 4'b1000 : 4'b0000;
            checks++; if (kb.release_pulse !== exp_rel) $display("FAIL mask_release cyc %0d got %b expected %b", m, kb.release_pulse, exp_rel); else passes++;
        end
        $display("test_no_repeat_mask: key3 press/release only");
    endtask

    // Key 2 press interrupted by reset after 5 counts; reset is last high on edge 9.
    task automatic test_reset_mid_debounce();
        logic [3:0] exp_press, exp_level, exp_rel;
        kb.key_in[2] = 1'b0;
        repeat (7) step();
        reset = 1'b1;
        for (int r = 8; r <= 9; r++) begin
            step();
            checks++; if (kb.key_level !== 4'b0000 || kb.press_pulse !== 4'b0000) $display("FAIL mid_reset_outputs cyc %0d level %b press %b expected 0000 0000", r, kb.key_level, kb.press_pulse); else passes++;
        end
        reset = 1'b0;
        for (int k = 10; k <= 22; k++) begin
            step();
            exp_press = (k == 19) ? 4'b0100 : 4'b0000;
            exp_level = (k >= 19) ? 4'b0100 : 4'b0000;
            checks++; if (kb.press_pulse !== exp_press) $display("FAIL mid_reset_press cyc %0d got %b expected %b", k, kb.press_pulse, exp_press); else passes++;
            checks++; if (kb.key_level !== exp_level) $display("FAIL mid_reset_level cyc %0d got %b expected %b", k, kb.key_level, exp_level); else passes++;
        end
        kb.key_in[2] = 1'b1;
        for (int m = 1; m <= 12; m++) begin
            step();
            exp_rel = (m == 10) ? 4'b0100 : 4'b0000;
            checks++; if (kb.release_pulse !== exp_rel) $display("FAIL mid_reset_release cyc %0d got %b expected %b", m, kb.release_pulse, exp_rel); else passes++;
        end
        $display("test_reset_mid_debounce: key2 re-debounced after reset");
    endtask

    task automatic test_simultaneous();
        logic [3:0] exp_press, exp_rel, exp_level, exp_rep;
        kb.key_in = 4'b0000;
        for (int k = 1; k <= 10; k++) begin
            step();
            exp_press = (k == 10) ? 4'b1111 : 4'b0000;
            checks++; if (kb.press_pulse !== exp_press) $display("FAIL simul_press cyc %0d got %b expected %b", k, kb.press_pulse, exp_press); else passes++;
        end
        // 4-clock glitch on held key 1 must not reach the level.
        kb.key_in = 4'b0010;
        for (int g = 1; g <= 16; g++) begin
            step();
            if (g == 4) kb.key_in = 4'b0000;
            checks++; if (kb.key_level !== 4'b1111 || kb.release_pulse !== 4'b0000 || kb.press_pulse !== 4'b0000) $display("FAIL held_glitch cyc %0d level %b release %b press %b expected 1111 0000 0000", g, kb.key_level, kb.release_pulse, kb.press_pulse); else passes++;
        end
        kb.key_in = 4'b1111;
        for (int m = 1; m <= 12; m++) begin
            step();
            exp_rel   = (m == 10) ? 4'b1111 : 4'b0000;
            exp_level = (m < 10) ? 4'b1111 : 4'b0000;
            exp_rep   = (m == 4 || m == 9) ? 4'b0011 : 4'b0000;
            checks++; if (kb.release_pulse !== exp_rel) $display("FAIL simul_release cyc %0d got %b expected %b", m, kb.release_pulse, exp_rel); else passes++;
            checks++; if (kb.key_level !== exp_level) $display("FAIL simul_level cyc %0d got %b expected %b", m, kb.key_level, exp_level); else passes++;
            checks++; if (kb.repeat_pulse !== exp_rep) $display("FAIL simul_repeat cyc %0d got %b expected %b", m, kb.repeat_pulse, exp_rep); else passes++;
        end
        // 4-clock glitch on released key 2 must not produce a press.
        kb.key_in = 4'b1011;
        for (int g = 1; g <= 16; g++) begin
            step();
            if (g == 4) kb.key_in = 4'b1111;
            checks++; if (kb.key_level !== 4'b0000 || kb.press_pulse !== 4'b0000) $display("FAIL idle_glitch cyc %0d level %b press %b expected 0000 0000", g, kb.key_level, kb.press_pulse); else passes++;
        end
        $display("test_simultaneous: four keys pulse together, glitches ignored");
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_auto_repeat();
        test_bounce();
        test_no_repeat_mask();
        test_reset_mid_debounce();
        test_simultaneous();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
